inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-002 start  input  1  one-cycle pulse; loads write pointer from base_addr, clears count and err.
REQ-003 base_addr  input  8  first instruction-memory word address.
REQ-004 in_valid  input  1  field set on in_* is valid.
REQ-005 in_ready  output  1  encoder accepts the field set this cycle.
REQ-006 in_op  input  5  mnemonic: 00 NOP, 01-0A R-type ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU, 0B-12 ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI, 13 BEQ, 14 BNE, 15 LW, 16 SW.
REQ-007 in_rs, in_rt, in_rd  input  5 each  register fields; in_imm  input  16  immediate/offset.
REQ-008 im_req  output  1  write request to instruction memory; im_gnt  input  1  memory accepts request.
REQ-009 im_addr  output  8  word address; im_wdata  output  32  encoded instruction.
REQ-010 count  output  9  instructions written since start; err  output  1  sticky invalid-mnemonic flag.

Function
REQ-011 R-type SHALL encode {6'h00, rs, rt, rd, 5'h00, funct}, funct 20,21,22,23,24,25,26,27,2A,2B for codes 01-0A in order.
REQ-012 I-type SHALL encode {opcode, rs, rt, imm}, opcode 08,09,0A,0B,0C,0D,0E,0F,04,05,23,2B for codes 0B-16 in order; LUI forces rs=0.
REQ-013 NOP (code 00) SHALL encode 32'h00000000 irrespective of other fields.
REQ-014 Codes 17-1F SHALL be accepted (in_ready honoured), not enqueued, and set err.
REQ-015 Encoding SHALL be registered: accepted field set enters a 4-entry FIFO of encoded words one cycle after the in_valid&in_ready edge.
REQ-016 in_ready SHALL be 1 when FIFO occupancy plus pending encode register is below 4.
REQ-017 im_req SHALL be 1 whenever FIFO non-empty; im_wdata = head entry; im_addr = write pointer.
REQ-018 im_req and its data/address SHALL be held stable until im_gnt; on im_req&im_gnt, pop head, increment write pointer (mod 256 wrap) and count.
REQ-019 count SHALL saturate at 256.
REQ-020 Simultaneous push and pop with FIFO full SHALL be impossible (REQ-016); push and pop same cycle at any other occupancy SHALL keep occupancy unchanged.
REQ-021 start SHALL flush FIFO and encode register, and take priority over same-cycle accept and grant (grant that cycle is not counted).
REQ-022 Best-case latency: accept at edge N, im_req high after edge N+1 with new word.
REQ-023 FSM states IDLE (after reset, until start; in_ready=0, im_req=0) and RUN (after start); start in RUN re-enters RUN with fresh pointer.

Reset
REQ-024 reset_n low SHALL asynchronously force: state IDLE, FIFO empty, encode register empty, write pointer 0, count 0, err 0, in_ready 0, im_req 0, im_addr 0, im_wdata 0.
REQ-025 Reset mid-write SHALL drop the in-flight request with no further im_req until next start.

Structure
REQ-026 Mnemonic codes, opcode and funct constants SHALL live in the shared MIPS package, shared with the controller decoder.
REQ-027 The FIFO SHALL be a sub-module inst_fifo (parameter depth 4, width 32).

Verification
REQ-028 start base_addr=10, ADD rs=1 rt=2 rd=3, gnt=1 -> im_addr 10, im_wdata 00221820, count 1.
REQ-029 ADDI rs=1 rt=2 imm=FFFF, then SW rs=29 rt=8 imm=4 -> 2022FFFF at 0, AFA80004 at 1.
REQ-030 im_gnt=0 with 5 back-to-back inputs -> in_ready falls after 4 accepted, im_req/data stable; gnt=1 drains in order.
REQ-031 in_op=1A -> err=1, no im_req, count unchanged; next valid op still written.
REQ-032 base_addr=FF, two instructions -> addresses FF then 00.
REQ-033 reset_n low while im_req pending -> all outputs 0 immediately; no write after release until start.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared MIPS encoding constants: mnemonic codes, primary opcodes, R-type funct
// values and the field-set-to-instruction-word encoder.
package inst_encoder_pkg;

    localparam int unsigned OP_W       = 5;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned CNT_W      = 9;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = 9'd256;

    // Mnemonic codes presented on in_op
    localparam logic [OP_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OP_W-1:0] OP_ADD   = 5'h01;
    localparam logic [OP_W-1:0] OP_ADDU  = 5'h02;
    localparam logic [OP_W-1:0] OP_SUB   = 5'h03;
    localparam logic [OP_W-1:0] OP_SUBU  = 5'h04;
    localparam logic [OP_W-1:0] OP_AND   = 5'h05;
    localparam logic [OP_W-1:0] OP_OR    = 5'h06;
    localparam logic [OP_W-1:0] OP_XOR   = 5'h07;
    localparam logic [OP_W-1:0] OP_NOR   = 5'h08;
    localparam logic [OP_W-1:0] OP_SLT   = 5'h09;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'h0A;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'h0B;
    localparam logic [OP_W-1:0] OP_ADDIU = 5'h0C;
    localparam logic [OP_W-1:0] OP_SLTI  = 5'h0D;
    localparam logic [OP_W-1:0] OP_SLTIU = 5'h0E;
    localparam logic [OP_W-1:0] OP_ANDI  = 5'h0F;
    localparam logic [OP_W-1:0] OP_ORI   = 5'h10;
    localparam logic [OP_W-1:0] OP_XORI  = 5'h11;
    localparam logic [OP_W-1:0] OP_LUI   = 5'h12;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'h13;
    localparam logic [OP_W-1:0] OP_BNE   = 5'h14;
    localparam logic [OP_W-1:0] OP_LW    = 5'h15;
    localparam logic [OP_W-1:0] OP_SW    = 5'h16;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return op <= OP_SW;
    endfunction

    function automatic logic [5:0] funct_of(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD:  return FN_ADD;
            OP_ADDU: return FN_ADDU;
            OP_SUB:  return FN_SUB;
            OP_SUBU: return FN_SUBU;
            OP_AND:  return FN_AND;
            OP_OR:   return FN_OR;
            OP_XOR:  return FN_XOR;
            OP_NOR:  return FN_NOR;
            OP_SLT:  return FN_SLT;
            default: return FN_SLTU;
        endcase
    endfunction

    function automatic logic [5:0] opcode_of(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI:  return OPC_ADDI;
            OP_ADDIU: return OPC_ADDIU;
            OP_SLTI:  return OPC_SLTI;
            OP_SLTIU: return OPC_SLTIU;
            OP_ANDI:  return OPC_ANDI;
            OP_ORI:   return OPC_ORI;
            OP_XORI:  return OPC_XORI;
            OP_LUI:   return OPC_LUI;
            OP_BEQ:   return OPC_BEQ;
            OP_BNE:   return OPC_BNE;
            OP_LW:    return OPC_LW;
            default:  return OPC_SW;
        endcase
    endfunction

    // NOP and out-of-range codes encode to zero; LUI has no rs source
    function automatic logic [INST_W-1:0] encode_inst(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [IMM_W-1:0] imm
    );
        logic [INST_W-1:0] w;
        w = '0;
        if (op == OP_NOP) begin
            w = '0;
        end else if (op <= OP_SLTU) begin
            w = {OPC_SPECIAL, rs, rt, rd, 5'h00, funct_of(op)};
        end else if (op <= OP_SW) begin
            w = {opcode_of(op), (op == OP_LUI) ? 5'h00 : rs, rt, imm};
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Small synchronous FIFO of encoded words with flush; head is presented
// combinationally and reads as zero when empty.
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop) rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            case ({push, pop})
                2'b10:   count_q <= CW'(count_q + 1'b1);
                2'b01:   count_q <= CW'(count_q - 1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_encoder.sv
// Encodes MIPS field sets into instruction words and streams them into
// instruction memory at consecutive word addresses starting at base_addr.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              im_req,
    input  logic              im_gnt,
    output logic [ADDR_W-1:0] im_addr,
    output logic [INST_W-1:0] im_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q,     state_d;
    logic [ADDR_W-1:0]     wptr_q,      wptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic                  err_q,       err_d;
    logic                  enc_valid_q, enc_valid_d;
    logic [INST_W-1:0]     enc_word_q,  enc_word_d;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] occupancy;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Pending encode word counts against capacity so an accept never overflows
    assign occupancy = FIFO_CNT_W'(fifo_count + FIFO_CNT_W'(enc_valid_q));
    assign in_ready  = (state_q == ST_RUN) && (occupancy < FIFO_CNT_W'(FIFO_DEPTH));
    assign im_req    = !fifo_empty;
    assign accept    = in_valid && in_ready && !start;
    assign push      = enc_valid_q && !start;
    assign pop       = im_req && im_gnt && !start;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (start),
        .push    (push),
        .wdata   (enc_word_q),
        .pop     (pop),
        .rdata   (im_wdata),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            enc_valid_q <= 1'b0;
            enc_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            enc_valid_q <= enc_valid_d;
            enc_word_q  <= enc_word_d;
        end
    end

    // start wins over any same-cycle accept or grant
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        err_d       = err_q;
        enc_valid_d = 1'b0;
        enc_word_d  = enc_word_q;
        if (start) begin
            state_d = ST_RUN;
            wptr_d  = base_addr;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (op_is_valid(in_op)) begin
                            enc_valid_d = 1'b1;
                            enc_word_d  = encode_inst(in_op, in_rs, in_rt, in_rd, in_imm);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (pop) begin
                        wptr_d = ADDR_W'(wptr_q + 1'b1);
                        if (count_q != CNT_MAX) count_d = CNT_W'(count_q + 1'b1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign im_addr = wptr_q;
    assign count   = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder.
module tb_inst_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic        im_req;
    logic        im_gnt;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic [8:0]  count;
    logic        err;

    int checks   = 0;
    int failures = 0;

    inst_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .im_req    (im_req),
        .im_gnt    (im_gnt),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        step();
        start     = 1'b0;
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm);
        in_op  = op;
        in_rs  = rs;
        in_rt  = rt;
        in_rd  = rd;
        in_imm = imm;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, im_req, im_addr, im_wdata, count, err} !== 51'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b req=%b addr=%h wdata=%h cnt=%0d err=%b exp all 0",
                     in_ready, im_req, im_addr, im_wdata, count, err);
        end
        reset_n  = 1'b1;
        in_valid = 1'b1;
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        step();
        checks++;
        if ({in_ready, im_req} !== 2'b00) begin
            failures++;
            $display("FAIL idle_no_ready got rdy=%b req=%b exp 0 0", in_ready, im_req);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        im_gnt = 1'b0;
        do_start(8'h0A);
        checks++;
        if ({in_ready, im_req, im_addr, count} !== {1'b1, 1'b0, 8'h0A, 9'd0}) begin
            failures++;
            $display("FAIL add_after_start got rdy=%b req=%b addr=%h cnt=%0d exp 1 0 0a 0",
                     in_ready, im_req, im_addr, count);
        end
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (im_req !== 1'b0) begin
            failures++;
            $display("FAIL add_latency_n got req=%b exp 0", im_req);
        end
        step();
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h0A, 32'h00221820}) begin
            failures++;
            $display("FAIL add_word got req=%b addr=%h wdata=%h exp 1 0a 00221820", im_req, im_addr, im_wdata);
        end
        im_gnt = 1'b1;
        step();
        im_gnt = 1'b0;
        checks++;
        if ({im_req, im_addr, count} !== {1'b0, 8'h0B, 9'd1}) begin
            failures++;
            $display("FAIL add_after_gnt got req=%b addr=%h cnt=%0d exp 0 0b 1", im_req, im_addr, count);
        end
    endtask

    task automatic test_encode_table();
        logic [4:0]  t_op  [9] = '{5'h01, 5'h0B, 5'h16, 5'h12, 5'h00, 5'h0A, 5'h14, 5'h08, 5'h15};
        logic [4:0]  t_rs  [9] = '{5'd1,  5'd1,  5'd29, 5'd5,  5'd7,  5'd4,  5'd1,  5'd31, 5'd2};
        logic [4:0]  t_rt  [9] = '{5'd2,  5'd2,  5'd8,  5'd3,  5'd9,  5'd5,  5'd2,  5'd31, 5'd9};
        logic [4:0]  t_rd  [9] = '{5'd3,  5'd0,  5'd0,  5'd0,  5'd11, 5'd6,  5'd0,  5'd31, 5'd0};
        logic [15:0] t_imm [9] = '{16'h0, 16'hFFFF, 16'h0004, 16'h1234, 16'hBEEF, 16'h0, 16'h0010, 16'h0, 16'h8000};
        logic [31:0] t_exp [9] = '{32'h00221820, 32'h2022FFFF, 32'hAFA80004, 32'h3C031234, 32'h00000000,
                                   32'h0085302B, 32'h14220010, 32'h03FFF827, 32'h8C498000};
        im_gnt = 1'b0;
        do_start(8'h40);
        for (int i = 0; i < 9; i++) begin
            set_fields(t_op[i], t_rs[i], t_rt[i], t_rd[i], t_imm[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            checks++;
            if ({im_req, im_addr, im_wdata} !== {1'b1, 8'(8'h40 + i), t_exp[i]}) begin
                failures++;
                $display("FAIL encode_%0d got req=%b addr=%h wdata=%h exp 1 %h %h",
                         i, im_req, im_addr, im_wdata, 8'(8'h40 + i), t_exp[i]);
            end
            im_gnt = 1'b1;
            step();
            im_gnt = 1'b0;
        end
        checks++;
        if (count !== 9'd9) begin
            failures++;
            $display("FAIL encode_count got %0d exp 9", count);
        end
    endtask

    task automatic test_back_to_back();
        im_gnt = 1'b1;
        do_start(8'h00);
        set_fields(5'h0B, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        in_valid = 1'b1;
        step();
        set_fields(5'h16, 5'd29, 5'd8, 5'd0, 16'h0004);
        step();
        in_valid = 1'b0;
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h00, 32'h2022FFFF}) begin
            failures++;
            $display("FAIL b2b_first got req=%b addr=%h wdata=%h exp 1 00 2022ffff", im_req, im_addr, im_wdata);
        end
        step();
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h01, 32'hAFA80004}) begin
            failures++;
            $display("FAIL b2b_second got req=%b addr=%h wdata=%h exp 1 01 afa80004", im_req, im_addr, im_wdata);
        end
        step();
        checks++;
        if ({im_req, count} !== {1'b0, 9'd2}) begin
            failures++;
            $display("FAIL b2b_done got req=%b cnt=%0d exp 0 2", im_req, count);
        end
        im_gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        int  got;
        bit  drop;
        im_gnt = 1'b0;
        do_start(8'h20);
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_fields(5'h0B, 5'd0, 5'd1, 5'd0, 16'(k));
            step();
        end
        set_fields(5'h0B, 5'd0, 5'd1, 5'd0, 16'd5);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({in_ready, im_req, im_addr, im_wdata} !== {1'b0, 1'b1, 8'h20, 32'h20010001}) begin
                failures++;
                $display("FAIL bp_hold_%0d got rdy=%b req=%b addr=%h wdata=%h exp 0 1 20 20010001",
                         c, in_ready, im_req, im_addr, im_wdata);
            end
            step();
        end
        im_gnt = 1'b1;
        got    = 0;
        drop   = 1'b0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (in_valid && in_ready) drop = 1'b1;
            if (im_req) begin
                checks++;
                if ({im_addr, im_wdata} !== {8'(8'h20 + got), 32'h20010000 | 32'(got + 1)}) begin
                    failures++;
                    $display("FAIL bp_drain_%0d got addr=%h wdata=%h exp %h %h", got, im_addr, im_wdata,
                             8'(8'h20 + got), 32'h20010000 | 32'(got + 1));
                end
                got++;
            end
            step();
            if (drop) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 5 || count !== 9'd5) begin
            failures++;
            $display("FAIL bp_total got words=%0d cnt=%0d exp 5 5", got, count);
        end
        im_gnt = 1'b0;
    endtask

    task automatic test_invalid();
        im_gnt = 1'b1;
        do_start(8'h30);
        set_fields(5'h1A, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL inv_err got %b exp 1", err);
        end
        step();
        checks++;
        if ({im_req, count} !== {1'b0, 9'd0}) begin
            failures++;
            $display("FAIL inv_no_write got req=%b cnt=%0d exp 0 0", im_req, count);
        end
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h30, 32'h00221820}) begin
            failures++;
            $display("FAIL inv_next_word got req=%b addr=%h wdata=%h exp 1 30 00221820", im_req, im_addr, im_wdata);
        end
        step();
        checks++;
        if ({count, err} !== {9'd1, 1'b1}) begin
            failures++;
            $display("FAIL inv_sticky got cnt=%0d err=%b exp 1 1", count, err);
        end
        do_start(8'h30);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL inv_start_clears got err=%b exp 0", err);
        end
        im_gnt = 1'b0;
    endtask

    task automatic test_wrap();
        im_gnt = 1'b1;
        do_start(8'hFF);
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        set_fields(5'h0B, 5'd1, 5'd2, 5'd0, 16'hFFFF);
        step();
        in_valid = 1'b0;
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'hFF, 32'h00221820}) begin
            failures++;
            $display("FAIL wrap_first got req=%b addr=%h wdata=%h exp 1 ff 00221820", im_req, im_addr, im_wdata);
        end
        step();
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h00, 32'h2022FFFF}) begin
            failures++;
            $display("FAIL wrap_second got req=%b addr=%h wdata=%h exp 1 00 2022ffff", im_req, im_addr, im_wdata);
        end
        step();
        checks++;
        if ({im_addr, count} !== {8'h01, 9'd2}) begin
            failures++;
            $display("FAIL wrap_done got addr=%h cnt=%0d exp 01 2", im_addr, count);
        end
        im_gnt = 1'b0;
    endtask

    task automatic test_start_priority();
        im_gnt = 1'b0;
        do_start(8'h50);
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        start     = 1'b1;
        base_addr = 8'h60;
        im_gnt    = 1'b1;
        in_valid  = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        im_gnt   = 1'b0;
        checks++;
        if ({im_req, im_addr, count} !== {1'b0, 8'h60, 9'd0}) begin
            failures++;
            $display("FAIL start_prio got req=%b addr=%h cnt=%0d exp 0 60 0", im_req, im_addr, count);
        end
        step();
        checks++;
        if (im_req !== 1'b0) begin
            failures++;
            $display("FAIL start_prio_noacc got req=%b exp 0", im_req);
        end
    endtask

    task automatic test_saturate();
        im_gnt = 1'b1;
        do_start(8'h00);
        set_fields(5'h00, 5'd0, 5'd0, 5'd0, 16'h0);
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) step();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if ({count, err} !== {9'd256, 1'b0}) begin
            failures++;
            $display("FAIL saturate got cnt=%0d err=%b exp 256 0", count, err);
        end
        im_gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        im_gnt = 1'b0;
        do_start(8'h70);
        set_fields(5'h01, 5'd1, 5'd2, 5'd3, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (im_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pending got req=%b exp 1", im_req);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, im_req, im_addr, im_wdata, count, err} !== 51'd0) begin
            failures++;
            $display("FAIL rst_mid_async got rdy=%b req=%b addr=%h wdata=%h cnt=%0d err=%b exp all 0",
                     in_ready, im_req, im_addr, im_wdata, count, err);
        end
        #2 reset_n = 1'b1;
        im_gnt   = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({in_ready, im_req, count} !== {1'b0, 1'b0, 9'd0}) begin
                failures++;
                $display("FAIL rst_mid_quiet_%0d got rdy=%b req=%b cnt=%0d exp 0 0 0", c, in_ready, im_req, count);
            end
        end
        in_valid = 1'b0;
        im_gnt   = 1'b0;
        do_start(8'h70);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({im_req, im_addr, im_wdata} !== {1'b1, 8'h70, 32'h00221820}) begin
            failures++;
            $display("FAIL rst_mid_restart got req=%b addr=%h wdata=%h exp 1 70 00221820", im_req, im_addr, im_wdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 8'h00;
        in_valid  = 1'b0;
        im_gnt    = 1'b0;
        set_fields(5'h00, 5'd0, 5'd0, 5'd0, 16'h0);
        test_reset();
        test_add();
        test_encode_table();
        test_back_to_back();
        test_backpressure();
        test_invalid();
        test_wrap();
        test_start_priority();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
